// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR memory interface: bus loads, gate_mdr drive, req/ack handshake, watchdog abort.
// Latency: mem_req the cycle after mio_en, r one cycle after ack; memory stalls by withholding mem_ack.
module lc3_mem_if #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    inout  wire  [15:0] data_bus_io,
    input  logic        ld_mar_i,
    input  logic        ld_mdr_i,
    input  logic        gate_mdr_i,
    input  logic        mio_en_i,
    input  logic        r_w_i,
    output logic        r_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        mem_err_o
);

    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [15:0]   mar_q;
    logic [15:0]   mdr_q;
    logic          r_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic          mem_err_q;
    logic [CW-1:0] wd_cnt_q;
    logic          wd_expire;

    // The abort fires on the BUSY cycle whose increment would reach the limit,
    // so exactly ACK_TIMEOUT BUSY cycles elapse before DONE.
    assign wd_expire = (ACK_TIMEOUT != 0) && ((32'(wd_cnt_q) + 32'd1) == ACK_TIMEOUT);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mar_q     <= '0;
            mdr_q     <= '0;
            r_q       <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_err_q <= 1'b0;
            wd_cnt_q  <= '0;
        end else begin
            r_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mio_en_i) begin
                        state_q   <= BUSY;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= r_w_i;
                        wd_cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        r_q       <= 1'b1;
                        if (!mem_we_q) begin
                            mdr_q <= mem_rdata_i;
                        end
                    end else if (wd_expire) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        r_q       <= 1'b1;
                        mem_err_q <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase

            // Address and write data stay frozen for the whole memory access.
            if (ld_mar_i && (state_q != BUSY)) begin
                mar_q <= data_bus_io;
            end
            if (ld_mdr_i && !mio_en_i && (state_q != BUSY)) begin
                mdr_q <= data_bus_io;
            end
        end
    end

    assign data_bus_io = gate_mdr_i ? mdr_q : 16'hzzzz;
    assign r_o         = r_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mar_q;
    assign mem_wdata_o = mdr_q;
    assign mem_err_o   = mem_err_q;

endmodule

// File: tb/tb_lc3_mem_if.sv
// Randomized scoreboard bench for lc3_mem_if: stimulus pushes transaction-level expectations,
// a negedge monitor pops them whenever the DUT pulses r.
module tb_lc3_mem_if;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_mar = 1'b0, ld_mdr = 1'b0, gate_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        tb_drv_en = 1'b0;
    logic [15:0] tb_drv = '0;
    wire  [15:0] data_bus;
    logic        r, mem_req, mem_we, mem_err;
    logic [15:0] mem_addr, mem_wdata;

    assign data_bus = tb_drv_en ? tb_drv : 16'hzzzz;

    lc3_mem_if #(.ACK_TIMEOUT(T)) dut (
        .clk_i(clk), .reset_i(reset), .data_bus_io(data_bus),
        .ld_mar_i(ld_mar), .ld_mdr_i(ld_mdr), .gate_mdr_i(gate_mdr),
        .mio_en_i(mio_en), .r_w_i(r_w), .r_o(r),
        .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .mem_err_o(mem_err)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          r_edge;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mdr;
        logic        we;
        logic        err;
    } exp_t;

    exp_t sb[$];

    // Architectural model: MAR, MDR and the sticky error flag.
    logic [15:0] m_mar = '0;
    logic [15:0] m_mdr = '0;
    logic        m_err = 1'b0;

    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && sb.size() > 0) begin
                chk("busy_addr", {16'h0, mem_addr}, {16'h0, sb[0].addr});
                chk("busy_wdata", {16'h0, mem_wdata}, {16'h0, sb[0].wdata});
            end
            if (r) begin
                if (sb.size() == 0) begin
                    chk("spurious_r", {31'h0, r}, 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("r_edge", edge_cnt, mon_e.r_edge);
                    chk("addr", {16'h0, mem_addr}, {16'h0, mon_e.addr});
                    chk("we", {31'h0, mem_we}, {31'h0, mon_e.we});
                    chk("mdr_on_bus", {16'h0, data_bus}, {16'h0, mon_e.mdr});
                    chk("err", {31'h0, mem_err}, {31'h0, mon_e.err});
                    if (mon_e.we) chk("wdata", {16'h0, mem_wdata}, {16'h0, mon_e.wdata});
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_mar = '0; m_mdr = '0; m_err = 1'b0;
    endtask

    task automatic load_mar(input logic [15:0] v);
        @(posedge clk); #1;
        tb_drv = v; tb_drv_en = 1'b1; gate_mdr = 1'b0; ld_mar = 1'b1;
        @(posedge clk); #1;
        ld_mar = 1'b0; tb_drv_en = 1'b0; gate_mdr = 1'b1;
        m_mar = v;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        @(posedge clk); #1;
        tb_drv = v; tb_drv_en = 1'b1; gate_mdr = 1'b0; ld_mdr = 1'b1;
        @(posedge clk); #1;
        ld_mdr = 1'b0; tb_drv_en = 1'b0; gate_mdr = 1'b1;
        m_mdr = v;
    endtask

    // d = number of BUSY cycles before mem_ack; d >= T means memory never answers.
    task automatic access(input logic rw, input int d, input logic [15:0] rv,
                          input bit freeze, input bit prio);
        exp_t e;
        int   n;
        int   k;
        bit   tmo;
        @(posedge clk); #1;
        mio_en = 1'b1; r_w = rw;
        if (prio) begin
            ld_mdr = 1'b1; tb_drv = 16'($urandom); tb_drv_en = 1'b1; gate_mdr = 1'b0;
        end
        n   = edge_cnt + 1;
        tmo = (d >= T);
        e.r_edge = tmo ? n + T : n + 1 + d;
        e.addr   = m_mar;
        e.we     = rw;
        e.wdata  = m_mdr;
        if (!tmo && !rw) m_mdr = rv;
        if (tmo) m_err = 1'b1;
        e.mdr = m_mdr;
        e.err = m_err;
        sb.push_back(e);
        @(posedge clk); #1;
        mio_en = 1'b0; ld_mdr = 1'b0; tb_drv_en = 1'b0; gate_mdr = 1'b1;
        if (freeze) begin
            ld_mar = 1'b1; tb_drv = 16'h1234; tb_drv_en = 1'b1; gate_mdr = 1'b0;
        end
        k = 0;
        forever begin
            if (k == d) begin
                mem_ack = 1'b1; mem_rdata = rv;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; ld_mar = 1'b0; tb_drv_en = 1'b0; gate_mdr = 1'b1;
            k++;
            if (!mem_req) break;
            if (k > 50) begin
                chk("access_hang", k, 0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        do_reset();
        gate_mdr = 1'b1;
        #1;
        chk("rst_bus", {16'h0, data_bus}, 32'h0);
        chk("rst_r", {31'h0, r}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_err", {31'h0, mem_err}, 32'h0);
        chk("rst_addr", {16'h0, mem_addr}, 32'h0);

        // Read with ack two cycles after mem_req rises.
        load_mar(16'h3000);
        access(1'b0, 2, 16'hBEEF, 1'b0, 1'b0);
        chk("read_mdr_bus", {16'h0, data_bus}, 32'h0000BEEF);

        // Write with ack in the first BUSY cycle.
        load_mar(16'hFE06);
        load_mdr(16'h0041);
        access(1'b1, 0, 16'($urandom), 1'b0, 1'b0);
        chk("write_mdr_hold", {16'h0, data_bus}, 32'h00000041);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) load_mar(16'($urandom));
            if ($urandom_range(0, 1) == 1) load_mdr(16'($urandom));
            access(1'($urandom_range(0, 1)), int'($urandom_range(0, T - 1)),
                   16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // MAR freeze during BUSY, and bus load suppressed alongside mio_en.
        load_mar(16'h4321);
        access(1'b0, 3, 16'h5A5A, 1'b1, 1'b0);
        access(1'b1, 1, 16'h0, 1'b0, 1'b1);

        // Watchdog abort, then sticky error through later accesses.
        load_mdr(16'hC0DE);
        access(1'b0, 99, 16'hDEAD, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            access(1'($urandom_range(0, 1)), int'($urandom_range(0, T - 1)),
                   16'($urandom), 1'b0, 1'b0);
        end

        // Reset during BUSY cycle 2 of a read; a late ack must be ignored.
        load_mar(16'h7777);
        load_mdr(16'h8888);
        @(posedge clk); #1 mio_en = 1'b1; r_w = 1'b0;
        @(posedge clk); #1 mio_en = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy_req", {31'h0, mem_req}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m_mar = '0; m_mdr = '0; m_err = 1'b0;
        chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
        chk("mid_rst_mar", {16'h0, mem_addr}, 32'h0);
        chk("mid_rst_mdr", {16'h0, mem_wdata}, 32'h0);
        chk("mid_rst_err", {31'h0, mem_err}, 32'h0);
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        @(posedge clk); #1 mem_ack = 1'b0;
        chk("late_ack_r", {31'h0, r}, 32'h0);
        chk("late_ack_mdr", {16'h0, mem_wdata}, 32'h0);
        @(posedge clk); #1;
        chk("late_ack_req", {31'h0, mem_req}, 32'h0);

        for (int i = 0; i < 4; i++) begin
            load_mar(16'($urandom));
            access(1'($urandom_range(0, 1)), int'($urandom_range(0, T - 1)),
                   16'($urandom), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1 chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc3_mem_if.md
# lc3_mem_if

Memory interface for the LC-3 datapath: holds MAR and MDR, samples the shared 16-bit data bus when the control unit loads them, and drives MDR back onto the bus under gate_mdr. It runs a request/acknowledge handshake with external memory and returns the LC-3 "R" (memory ready) signal to the control FSM. A bounded-wait watchdog sets a sticky error flag if memory never acknowledges. The block sits between the bus and the memory port, opposite the ALU and other bus drivers.

## Interface
- ACK_TIMEOUT, 255: maximum BUSY cycles without mem_ack before a forced abort; 0 disables the watchdog.
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- data_bus  inout  16  shared datapath bus; sampled by ld_mar/ld_mdr, driven when gate_mdr=1, else 16'hzzzz.
- ld_mar  input  1  load MAR from data_bus.
- ld_mdr  input  1  load MDR from data_bus (only with mio_en=0).
- gate_mdr  input  1  drive MDR onto data_bus.
- mio_en  input  1  request a memory access.
- r_w  input  1  access direction: 1 = write, 0 = read.
- r  output  1  memory ready, one-cycle pulse at access completion.
- mem_req  output  1  memory request, registered.
- mem_we  output  1  write enable, valid while mem_req=1.
- mem_addr  output  16  equals MAR.
- mem_wdata  output  16  equals MDR.
- mem_rdata  input  16  read data, valid when mem_ack=1.
- mem_ack  input  1  memory acknowledge, sampled only in BUSY.
- mem_err  output  1  sticky watchdog-timeout flag.

## Operation
- Reset values: MAR=0, MDR=0, state IDLE, r=0, mem_req=0, mem_we=0, mem_err=0, watchdog count=0, data_bus undriven.
- FSM states and transitions:
  - IDLE: mio_en=1 moves to BUSY at the next edge and latches r_w into mem_we. mio_en=0 stays in IDLE.
  - BUSY: mem_req=1. mem_ack=1 moves to DONE. Watchdog count reaching ACK_TIMEOUT (nonzero) moves to DONE and sets mem_err.
  - DONE: r=1 and mem_req=0 for exactly one cycle, then IDLE unconditionally. mio_en is ignored in DONE.
- MAR: loaded from data_bus on ld_mar only in IDLE or DONE. It is frozen in BUSY, where ld_mar is ignored.
- MDR bus load: ld_mdr=1 with mio_en=0 loads MDR from data_bus in IDLE or DONE.
- MDR memory load: on the BUSY->DONE edge with mem_ack=1 and mem_we=0, MDR <= mem_rdata. ld_mdr is not required for this load.
- MDR hold: MDR is not modified by a write access or by a timeout abort.
- Simultaneous ld_mdr=1 with mio_en=1: the bus load is suppressed and the memory path has priority.
- Watchdog:
  - Counter of width ceil(log2(ACK_TIMEOUT+1)), minimum 1 bit.
  - Cleared on entry to BUSY; increments each BUSY cycle without ack.
  - Abort when count==ACK_TIMEOUT.
  - mem_ack in the same cycle as the timeout wins: normal completion, no error.
- mem_err: cleared only by reset.
- data_bus drive: combinational, MDR when gate_mdr=1, else high-Z.
- Reset asserted mid-access: return to IDLE with all reset values the following cycle. mem_req drops immediately after that edge. A pending ack is ignored.

## Timing
- Access latency: mio_en first seen in IDLE at edge N, then mem_req=1 from cycle N+1.
- Ack at the earliest point: if mem_ack=1 in cycle N+1, r=1 in cycle N+2 and IDLE in N+3. Minimum 3 cycles from mio_en to IDLE.
- Each wait cycle with mem_ack=0 adds one cycle.
- mem_addr and mem_wdata are stable for the whole of BUSY.
- Read data appears in MDR (and on the bus via gate_mdr) in the r=1 cycle.
- ld_mar/ld_mdr take effect at the edge that samples them; a value loaded at edge N is visible on mem_addr/mem_wdata in cycle N+1.
- Back-to-back accesses: mio_en=1 held through DONE starts the next access from IDLE, so the minimum period is 3 cycles.

## Test plan
- Reset, then gate_mdr=1 -> data_bus=16'h0000; r=0, mem_req=0, mem_err=0.
- Read: bus=16'h3000 with ld_mar; then mio_en=1, r_w=0; memory acks 2 cycles after mem_req with mem_rdata=16'hBEEF. Required: mem_addr=16'h3000, r pulses once, MDR=16'hBEEF, gate_mdr drives 16'hBEEF.
- Write: MAR=16'hFE06, bus=16'h0041 with ld_mdr (mio_en=0), then mio_en=1, r_w=1, ack in first BUSY cycle. Required: mem_we=1, mem_wdata=16'h0041, r at cycle N+2, MDR unchanged.
- Timeout: ACK_TIMEOUT=4, mem_ack held 0. Required: abort after 4 BUSY cycles, r pulses, mem_err=1 and stays 1 through later accesses until reset, MDR unchanged.
- Freeze and priority: ld_mar with bus=16'h1234 during BUSY -> mem_addr unchanged. ld_mdr with mio_en=1 in IDLE -> MDR not loaded from bus.
- Reset in BUSY cycle 2 of a read -> next cycle IDLE, mem_req=0, MAR=MDR=0. A subsequent ack has no effect.
